// File: rtl/stream_demux_w_qos_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_demux_w_qos_if
// Purpose  : Bundles the merged input stream and the per-destination output
//            streams of stream_demux_w_qos.
// Ports    : s_data_in/s_qos_in/s_id_in/s_last_in/s_valid_in/s_ready_out
//              - single merged input stream (id selects the destination)
//            m_data_out/m_qos_out/m_last_out/m_valid_out/m_ready_in
//              - STREAM_COUNT output streams, one slice per destination
// Modports : master - the environment (drives input beats, output readies)
//            slave  - the demux itself
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface stream_demux_w_qos_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_QOS__WIDTH = 2,
  parameter int STREAM_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
);

  // Merged input stream
  logic [T_DATA_WIDTH-1:0]                    s_data_in;
  logic [T_QOS__WIDTH-1:0]                    s_qos_in;
  logic [T_ID___WIDTH-1:0]                    s_id_in;
  logic                                       s_last_in;
  logic                                       s_valid_in;
  logic                                       s_ready_out;

  // Per-destination output streams
  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_out;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_out;
  logic [STREAM_COUNT-1:0]                    m_last_out;
  logic [STREAM_COUNT-1:0]                    m_valid_out;
  logic [STREAM_COUNT-1:0]                    m_ready_in;

  modport master (
    output s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in,
    input  s_ready_out,
    input  m_data_out, m_qos_out, m_last_out, m_valid_out,
    output m_ready_in
  );

  modport slave (
    input  s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in,
    output s_ready_out,
    output m_data_out, m_qos_out, m_last_out, m_valid_out,
    input  m_ready_in
  );

endinterface
`default_nettype wire

// File: rtl/stream_demux_w_qos.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_demux_w_qos
// Purpose  : Splits one merged stream (data/qos/id/last) back into
//            STREAM_COUNT output streams. The destination is taken from the
//            id of the first beat of a packet and held until its last beat.
//            Each output owns a FIFO_DEPTH-entry FIFO so a stalled consumer
//            only blocks packets that are addressed to it.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            bus        - stream_demux_w_qos_if.slave (input stream and
//                         per-output streams)
//            id_err_out - sticky id error flag, present only when
//                         STREAM_DEMUX_ID_CHECK_EN is defined
// Options  : STREAM_DEMUX_ID_CHECK_EN - adds id_err_out, set by an id change
//            inside a forwarded packet or by an invalid id at packet start.
//            Routing is identical with or without it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module stream_demux_w_qos #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_QOS__WIDTH = 2,
  parameter int STREAM_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux_w_qos_if.slave   bus
`ifdef STREAM_DEMUX_ID_CHECK_EN
  ,
  output logic                  id_err_out
`endif
);

  // FIFO_DEPTH is a power of two, so pointers wrap naturally at C_PTR_W bits.
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  // FIFO entry layout: {data, qos, last}
  localparam int C_ENT_W = T_DATA_WIDTH + T_QOS__WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // between packets, next beat decides the route
    ST_FWD  = 2'd1,   // inside a packet routed to lock_q
    ST_DROP = 2'd2    // inside a packet with an invalid id, beats discarded
  } state_t;

  state_t                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_q,  lock_d;

  logic [STREAM_COUNT-1:0] w_full;
  logic [STREAM_COUNT-1:0] w_valid;
  logic [STREAM_COUNT-1:0] w_push;
  logic [STREAM_COUNT-1:0] w_pop;
  logic [C_ENT_W-1:0]      w_head [STREAM_COUNT];

  logic                    w_id_valid;
  logic                    w_route;
  logic                    w_ready;
  logic                    w_accept;
  logic [T_ID___WIDTH-1:0] w_target;
  logic [C_ENT_W-1:0]      w_wr_entry;

  // Zero-extend both sides so the compare is unsigned and width-matched.
  assign w_id_valid = ({1'b0, bus.s_id_in} < (T_ID___WIDTH+1)'(STREAM_COUNT));

  //----------------------------------------------------------------------------
  // Route selection and input ready. Ready looks only at state, id and the
  // target FIFO's full flag, never at s_valid_in, and takes no credit from a
  // same-cycle pop on the target output.
  //----------------------------------------------------------------------------
  always_comb begin
    w_target = lock_q;
    w_route  = 1'b0;
    w_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_id_valid) begin
          w_target = bus.s_id_in;
          w_route  = 1'b1;
          w_ready  = !w_full[bus.s_id_in];
        end else begin
          w_ready  = 1'b1;          // invalid id: swallow the beat
        end
      end
      ST_FWD: begin
        w_target = lock_q;          // s_id_in is ignored mid-packet
        w_route  = 1'b1;
        w_ready  = !w_full[lock_q];
      end
      ST_DROP: begin
        w_ready  = 1'b1;
      end
      default: begin
        w_ready  = 1'b0;
      end
    endcase
  end

  // Ready is held low for the whole time reset is asserted, not just after
  // the first clock of reset.
  assign bus.s_ready_out = w_ready & rst_n;
  assign w_accept        = bus.s_valid_in & bus.s_ready_out;
  assign w_wr_entry      = {bus.s_data_in, bus.s_qos_in, bus.s_last_in};

  //----------------------------------------------------------------------------
  // Packet framing: next state and locked destination
  //----------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ST_IDLE: begin
        // A single-beat packet (last on the first beat) stays in IDLE.
        if (w_accept && !bus.s_last_in) begin
          if (w_id_valid) begin
            state_d = ST_FWD;
            lock_d  = bus.s_id_in;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_FWD, ST_DROP: begin
        if (w_accept && bus.s_last_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef STREAM_DEMUX_ID_CHECK_EN
  logic id_err_q, id_err_d;

  always_comb begin
    id_err_d = id_err_q;
    if (w_accept) begin
      if ((state_q == ST_FWD) && (bus.s_id_in != lock_q)) begin
        id_err_d = 1'b1;
      end
      if ((state_q == ST_IDLE) && !w_id_valid) begin
        id_err_d = 1'b1;
      end
    end
  end

  assign id_err_out = id_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lock_q   <= '0;
`ifdef STREAM_DEMUX_ID_CHECK_EN
      id_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
`ifdef STREAM_DEMUX_ID_CHECK_EN
      id_err_q <= id_err_d;
`endif
    end
  end

  //----------------------------------------------------------------------------
  // Per-output FIFOs
  //----------------------------------------------------------------------------
  for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_fifo
    logic [C_ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] cnt_q,    cnt_d;

    assign w_full[gi]  = (cnt_q == C_CNT_W'(FIFO_DEPTH));
    assign w_valid[gi] = (cnt_q != '0);
    assign w_push[gi]  = w_accept & w_route & (w_target == T_ID___WIDTH'(gi));
    assign w_pop[gi]   = w_valid[gi] & bus.m_ready_in[gi];
    assign w_head[gi]  = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (w_push[gi]) begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop[gi]) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      case ({w_push[gi], w_pop[gi]})
        2'b10:   cnt_d = cnt_q + C_CNT_W'(1);
        2'b01:   cnt_d = cnt_q - C_CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage needs no reset: a slot is only observed after it was written.
    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        mem_q[wr_ptr_q] <= w_wr_entry;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Output drive: head entry while non-empty, all-zero while empty
  //----------------------------------------------------------------------------
  assign bus.m_valid_out = w_valid;

  always_comb begin
    bus.m_data_out = '0;
    bus.m_qos_out  = '0;
    bus.m_last_out = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (w_valid[i]) begin
        bus.m_data_out[i] = w_head[i][C_ENT_W-1 -: T_DATA_WIDTH];
        bus.m_qos_out[i]  = w_head[i][T_QOS__WIDTH:1];
        bus.m_last_out[i] = w_head[i][0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_w_qos.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_stream_demux_w_qos
// Purpose  : Self-checking bench for stream_demux_w_qos. Directed scenarios
//            followed by randomized traffic, all checked every cycle against
//            a packet-level reference model (one expected-beat queue per
//            output). Define STREAM_DEMUX_ID_CHECK_EN to also check id_err_out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_stream_demux_w_qos;

  localparam int DW = 4;
  localparam int QW = 2;
  localparam int SC = 3;
  localparam int IW = $clog2(SC);
  localparam int FD = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [QW-1:0] q;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_w_qos_if #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC), .T_ID___WIDTH(IW)
  ) bus ();

`ifdef STREAM_DEMUX_ID_CHECK_EN
  logic id_err;
`endif

  stream_demux_w_qos #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC),
    .T_ID___WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_DEMUX_ID_CHECK_EN
    ,
    .id_err_out (id_err)
`endif
  );

  // Reference model: beats still owed by each output, in delivery order.
  beat_t exp_q [SC][$];
  bit    pkt_open;      // model is inside a packet
  int    pkt_dest;      // destination of the open packet, -1 = discarded
  bit    exp_err;
  bit    last_acc;      // the beat driven in the last step was accepted
  bit    s_in_pkt;      // stimulus-side packet tracking
  int    s_pkt_id;
  int    n_checks;
  int    n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Evaluated on the falling edge: compares DUT outputs with the model, then
  // advances the model by what the coming rising edge will transfer.
  task automatic eval_cycle();
    int    dest;
    bit    exp_rdy;
    beat_t got;
    beat_t want;
    for (int i = 0; i < SC; i++) begin
      check_eq($sformatf("m_valid[%0d]", i), 32'(bus.m_valid_out[i]), 32'(exp_q[i].size() != 0));
      got  = {bus.m_data_out[i], bus.m_qos_out[i], bus.m_last_out[i]};
      want = (exp_q[i].size() != 0) ? exp_q[i][0] : beat_t'(0);
      check_eq($sformatf("m_beat[%0d]", i), 32'(got), 32'(want));
    end
    if (pkt_open) dest = pkt_dest;
    else          dest = (int'(bus.s_id_in) < SC) ? int'(bus.s_id_in) : -1;
    exp_rdy = (dest < 0) ? 1'b1 : (exp_q[dest].size() < FD);
    check_eq("s_ready", 32'(bus.s_ready_out), 32'(exp_rdy));
`ifdef STREAM_DEMUX_ID_CHECK_EN
    check_eq("id_err", 32'(id_err), 32'(exp_err));
`endif
    last_acc = bus.s_valid_in && bus.s_ready_out;
    for (int i = 0; i < SC; i++) begin
      if (bus.m_valid_out[i] && bus.m_ready_in[i] && exp_q[i].size() != 0)
        void'(exp_q[i].pop_front());
    end
    if (last_acc) begin
      if (pkt_open && dest >= 0 && int'(bus.s_id_in) != dest) exp_err = 1'b1;
      if (!pkt_open && dest < 0) exp_err = 1'b1;
      if (dest >= 0) exp_q[dest].push_back({bus.s_data_in, bus.s_qos_in, bus.s_last_in});
      pkt_open = !bus.s_last_in;
      pkt_dest = dest;
    end
  endtask

  task automatic step(input bit v, input int id, input logic [DW-1:0] d,
                      input logic [QW-1:0] q, input bit l, input logic [SC-1:0] mr);
    @(posedge clk);
    #1;
    bus.s_valid_in = v;
    bus.s_id_in    = IW'(id);
    bus.s_data_in  = d;
    bus.s_qos_in   = q;
    bus.s_last_in  = l;
    bus.m_ready_in = mr;
    @(negedge clk);
    eval_cycle();
  endtask

  // Holds one beat until accepted, bounded so a stuck DUT cannot hang the run.
  task automatic send_beat(input int id, input logic [DW-1:0] d, input logic [QW-1:0] q,
                           input bit l, input logic [SC-1:0] mr);
    int guard = 0;
    do begin
      step(1'b1, id, d, q, l, mr);
      guard++;
    end while (!last_acc && guard < 50);
    if (!last_acc) check_eq("send_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic [SC-1:0] mr);
    for (int c = 0; c < n; c++)
      step(1'b0, int'($urandom_range(0, SC)), DW'($urandom), QW'($urandom), 1'($urandom), mr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.s_valid_in = 1'b1;
    bus.s_id_in    = IW'(1);
    bus.m_ready_in = '1;
    #1;
    check_eq("rst_s_ready", 32'(bus.s_ready_out), 32'd0);
    check_eq("rst_m_valid", 32'(bus.m_valid_out), 32'd0);
    for (int i = 0; i < SC; i++) exp_q[i].delete();
    pkt_open = 1'b0;
    exp_err  = 1'b0;
    s_in_pkt = 1'b0;
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_s_ready_hold", 32'(bus.s_ready_out), 32'd0);
    check_eq("rst_m_valid_hold", 32'(bus.m_valid_out), 32'd0);
    check_eq("rst_m_data", 32'(bus.m_data_out), 32'd0);
`ifdef STREAM_DEMUX_ID_CHECK_EN
    check_eq("rst_id_err", 32'(id_err), 32'd0);
`endif
    bus.s_valid_in = 1'b0;
    rst_n          = 1'b1;
  endtask

  // Random traffic: mostly consistent ids within a packet, occasional id
  // changes and invalid ids, per-output readiness drawn with rdy_pct.
  task automatic run_random(input int n, input int rdy_pct);
    bit            v = 1'b0;
    int            id = 0;
    logic [DW-1:0] d = '0;
    logic [QW-1:0] q = '0;
    bit            l = 1'b0;
    logic [SC-1:0] mr;
    for (int c = 0; c < n; c++) begin
      if (!(v && !last_acc)) begin
        v = ($urandom_range(0, 99) < 70);
        if (s_in_pkt)
          id = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, SC)) : s_pkt_id;
        else
          id = ($urandom_range(0, 9) == 0) ? SC : int'($urandom_range(0, SC - 1));
        d = DW'($urandom);
        q = QW'($urandom);
        l = ($urandom_range(0, 2) == 0);
      end
      for (int i = 0; i < SC; i++) mr[i] = ($urandom_range(0, 99) < rdy_pct);
      step(v, id, d, q, l, mr);
      if (v && last_acc) begin
        if (!s_in_pkt) s_pkt_id = id;
        s_in_pkt = !l;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pkt_open = 1'b0;
    pkt_dest = -1;
    exp_err  = 1'b0;
    last_acc = 1'b0;
    s_in_pkt = 1'b0;
    s_pkt_id = 0;
    rst_n          = 1'b0;
    bus.s_valid_in = 1'b1;
    bus.s_id_in    = IW'(1);
    bus.s_data_in  = '0;
    bus.s_qos_in   = '0;
    bus.s_last_in  = 1'b0;
    bus.m_ready_in = '1;

    // Reset with a pending beat, then a single-beat packet to output 1.
    do_reset();
    send_beat(1, 4'h5, 2'd1, 1'b1, 3'b111);
    idle(2, 3'b111);

    // Four-beat packet to output 2 with qos 3, all outputs ready.
    send_beat(2, 4'hA, 2'd3, 1'b0, 3'b111);
    send_beat(2, 4'hB, 2'd3, 1'b0, 3'b111);
    send_beat(2, 4'hC, 2'd3, 1'b0, 3'b111);
    send_beat(2, 4'hD, 2'd3, 1'b1, 3'b111);
    idle(3, 3'b111);

    // Head-of-line: output 0 stalled, its FIFO fills after two beats.
    send_beat(0, 4'h1, 2'd0, 1'b0, 3'b110);
    send_beat(0, 4'h2, 2'd1, 1'b0, 3'b110);
    repeat (3) step(1'b1, 0, 4'h3, 2'd2, 1'b0, 3'b110);
    check_eq("hol_stalled", 32'(last_acc), 32'd0);
    send_beat(0, 4'h3, 2'd2, 1'b0, 3'b111);
    send_beat(0, 4'h4, 2'd3, 1'b1, 3'b111);
    send_beat(1, 4'h6, 2'd0, 1'b0, 3'b111);
    send_beat(1, 4'h7, 2'd1, 1'b1, 3'b111);
    idle(4, 3'b111);

    // Locked route: id changes to 2 mid-packet, all beats stay on output 0.
    send_beat(0, 4'h8, 2'd1, 1'b0, 3'b111);
    send_beat(2, 4'h9, 2'd1, 1'b0, 3'b111);
    send_beat(2, 4'hA, 2'd1, 1'b0, 3'b111);
    send_beat(2, 4'hB, 2'd1, 1'b1, 3'b111);
    idle(3, 3'b111);

    // Invalid id packet is swallowed, next packet routes normally.
    send_beat(3, 4'hC, 2'd2, 1'b0, 3'b111);
    send_beat(3, 4'hD, 2'd2, 1'b0, 3'b111);
    send_beat(3, 4'hE, 2'd2, 1'b1, 3'b111);
    send_beat(1, 4'hF, 2'd3, 1'b1, 3'b111);
    idle(3, 3'b111);

    // Fill output 1, then stream through it while it drains.
    send_beat(1, 4'h1, 2'd0, 1'b0, 3'b101);
    send_beat(1, 4'h2, 2'd1, 1'b0, 3'b101);
    send_beat(1, 4'h3, 2'd2, 1'b0, 3'b111);
    send_beat(1, 4'h4, 2'd3, 1'b0, 3'b111);
    send_beat(1, 4'h5, 2'd0, 1'b1, 3'b111);
    idle(4, 3'b111);

    // Randomized traffic with varying back-pressure and a mid-run reset.
    run_random(1500, 80);
    run_random(1500, 30);
    do_reset();
    run_random(1500, 60);
    idle(10, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
